// File: rtl/fma16_pkg.sv
// Shared fp16 constants, flag ordering and the result-stage entry type
// used throughout the fma16 output path.
package fma16_pkg;

    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int FP_W   = 16;
    localparam int FLAG_W = 4;

    localparam logic [FP_W-1:0] NAN_CANON = 16'h7e00;
    localparam logic [FP_W-1:0] INF_P     = 16'h7c00;
    localparam logic [FP_W-1:0] INF_N     = 16'hfc00;

    typedef enum logic [1:0] {
        NX = 2'd0,
        UF = 2'd1,
        OF = 2'd2,
        NV = 2'd3
    } flag_idx_e;

    typedef struct packed {
        logic [FP_W-1:0]   result;
        logic [FLAG_W-1:0] flags;
    } entry_t;

    // Encoding mirrors {main_v, skid_v} so the state bits are the valid bits.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } buf_state_e;

    function automatic logic is_nan(input logic [FP_W-1:0] v);
        return (v[14:10] == 5'h1f) && (v[MAN_W-1:0] != '0);
    endfunction

    function automatic logic is_snan(input logic [FP_W-1:0] v);
        return is_nan(v) && !v[9];
    endfunction

    function automatic logic is_inf(input logic [FP_W-1:0] v);
        return (v[14:10] == 5'h1f) && (v[MAN_W-1:0] == '0);
    endfunction

endpackage

// File: rtl/fma16_skid_buf.sv
// Two-entry valid/ready skid buffer; o_ready comes straight from a register
// so upstream never sees a combinational path from i_ready.
import fma16_pkg::*;

module fma16_skid_buf (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_valid,
    output logic   o_ready,
    input  entry_t i_data,
    output logic   o_valid,
    input  logic   i_ready,
    output entry_t o_data
);

    buf_state_e r_state;
    buf_state_e w_state_nxt;
    entry_t     r_main;
    entry_t     r_skid;
    logic       w_in_hs;
    logic       w_out_hs;
    logic       w_load_main;
    logic       w_load_skid;
    logic       w_skid_to_main;

    assign w_in_hs  = i_valid && !r_state[0];
    assign w_out_hs = r_state[1] && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_hs) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_hs && w_out_hs) begin
                    w_load_main = 1'b1;
                end else if (w_in_hs) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_hs) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_hs) begin
                    w_state_nxt    = ST_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= i_data;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_valid = r_state[1];
    assign o_ready = !r_state[0];
    assign o_data  = r_main;

endmodule

// File: rtl/fma16_result_stage.sv
// fma16 output stage: derives IEEE exception flags for each resolved result,
// buffers result+flags through a skid buffer and accumulates sticky flags.
import fma16_pkg::*;

module fma16_result_stage (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   x,
    input  logic [FP_W-1:0]   y,
    input  logic [FP_W-1:0]   z,
    input  logic [FP_W-1:0]   result,
    input  logic              special_case,
    input  logic              inexact_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP_W-1:0]   out_result,
    output logic [FLAG_W-1:0] out_flags,
    input  logic              clear_flags,
    output logic [FLAG_W-1:0] sticky_flags
);

    logic [FLAG_W-1:0] w_flags;
    logic              w_nv;
    logic              w_of;
    logic              w_uf;
    logic              w_round_nx;
    logic              w_out_hs;
    entry_t            w_in_entry;
    entry_t            w_out_entry;
    logic [FLAG_W-1:0] r_sticky;

    // A canonical NaN with no NaN operand can only come from an invalid op.
    assign w_nv = is_snan(x) || is_snan(y) || is_snan(z) ||
                  ((result == NAN_CANON) && !is_nan(x) && !is_nan(y) && !is_nan(z));
    assign w_of = is_inf(result) && !is_inf(x) && !is_inf(y) && !is_inf(z) && !w_nv;
    assign w_round_nx = inexact_in && !special_case;
    assign w_uf = (result[14:10] == '0) && (result[MAN_W-1:0] != '0) && w_round_nx;

    always_comb begin
        w_flags     = '0;
        w_flags[NV] = w_nv;
        w_flags[OF] = w_of;
        w_flags[UF] = w_uf;
        w_flags[NX] = w_of || w_round_nx;
    end

    assign w_in_entry.result = result;
    assign w_in_entry.flags  = w_flags;

    fma16_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_entry),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_entry)
    );

    assign out_result = w_out_entry.result;
    assign out_flags  = w_out_entry.flags;
    assign w_out_hs   = out_valid && out_ready;

    // Clear takes effect before the OR so a same-cycle transfer survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= '0;
        end else if (w_out_hs) begin
            r_sticky <= (clear_flags ? '0 : r_sticky) | out_flags;
        end else if (clear_flags) begin
            r_sticky <= '0;
        end
    end

    assign sticky_flags = r_sticky;

endmodule

// File: tb/tb_fma16_result_stage.sv
// Scoreboard bench for fma16_result_stage: expected entries are queued on
// input handshakes and compared on output handshakes.
import fma16_pkg::*;

module tb_fma16_result_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0, y = '0, z = '0, result = '0;
    logic        special_case = 1'b0;
    logic        inexact_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic        clear_flags = 1'b0;
    logic [3:0]  sticky_flags;

    logic [3:0]  exp_flags_drv = '0;
    entry_t      sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_out = 0;

    always #5 clk = ~clk;

    fma16_result_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x            (x),
        .y            (y),
        .z            (z),
        .result       (result),
        .special_case (special_case),
        .inexact_in   (inexact_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .clear_flags  (clear_flags),
        .sticky_flags (sticky_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes are judged at the negedge, ahead of the posedge that commits them.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    entry_t e;
                    e = sb.pop_front();
                    chk("out_result", out_result, e.result);
                    chk("out_flags", out_flags, e.flags);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{result: result, flags: exp_flags_drv});
            end
        end
    end

    task automatic drive(input logic [15:0] ix, iy, iz, ires, input logic isc, inx,
                         input logic [3:0] eflags);
        x = ix; y = iy; z = iz; result = ires;
        special_case = isc; inexact_in = inx; exp_flags_drv = eflags;
    endtask

    task automatic send(input logic [15:0] ix, iy, iz, ires, input logic isc, inx,
                        input logic [3:0] eflags);
        bit ok;
        ok = 1'b0;
        drive(ix, iy, iz, ires, isc, inx, eflags);
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!out_valid && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
    endtask

    initial begin
        int n_before;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_result", out_result, 16'h0);
        chk("rst_out_flags", out_flags, 4'h0);
        chk("rst_sticky", sticky_flags, 4'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;

        send(16'h3c00, 16'h4000, 16'h0000, 16'h4000, 1'b0, 1'b0, 4'b0000);
        chk("lat_out_valid", out_valid, 1'b1);
        chk("lat_out_result", out_result, 16'h4000);
        chk("lat_out_flags", out_flags, 4'b0000);
        chk("lat_sticky", sticky_flags, 4'b0000);

        send(16'h0000, 16'h7c00, 16'h0000, 16'h7e00, 1'b1, 1'b0, 4'b1000);
        send(16'h7d00, 16'h3c00, 16'h0000, 16'h7e00, 1'b1, 1'b0, 4'b1000);
        send(16'h7e00, 16'h3c00, 16'h0000, 16'h7e00, 1'b1, 1'b0, 4'b0000);
        wait_drain();
        chk("sticky_nv", sticky_flags, 4'b1000);
        pulse_clear();
        chk("sticky_clear", sticky_flags, 4'b0000);

        send(16'h7bff, 16'h7bff, 16'h0000, 16'h7c00, 1'b1, 1'b0, 4'b0101);
        send(16'h0400, 16'h0400, 16'h0000, 16'h0001, 1'b0, 1'b1, 4'b0011);
        wait_drain();
        chk("sticky_of_uf", sticky_flags, 4'b0111);

        // Backpressure: third input must wait upstream until the skid drains.
        out_ready = 1'b0;
        n_before = n_out;
        @(posedge clk); #1;
        drive(16'h3c00, 16'h3c00, 16'h0000, 16'h3c01, 1'b0, 1'b0, 4'b0000);
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready_a", in_ready, 1'b1);
        @(posedge clk); #1;
        drive(16'h3c00, 16'h3c00, 16'h0000, 16'h3c02, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        chk("bp_ready_b", in_ready, 1'b1);
        @(posedge clk); #1;
        drive(16'h3c00, 16'h3c00, 16'h0000, 16'h3c03, 1'b0, 1'b1, 4'b0001);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_low", in_ready, 1'b0);
        chk("bp_hold_result", out_result, 16'h3c01);
        chk("bp_sb_depth", sb.size(), 32'd2);
        out_ready = 1'b1;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("bp_c_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();
        chk("bp_out_count", n_out - n_before, 32'd3);

        // Clear coinciding with a transfer keeps that transfer's flags.
        pulse_clear();
        send(16'h0000, 16'h7c00, 16'h0000, 16'h7e00, 1'b1, 1'b0, 4'b1000);
        wait_drain();
        chk("sticky_pre", sticky_flags, 4'b1000);
        out_ready = 1'b0;
        send(16'h3c00, 16'h3c00, 16'h0000, 16'h3c01, 1'b0, 1'b1, 4'b0001);
        chk("clr_hold_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        chk("sticky_clr_hs", sticky_flags, 4'b0001);
        wait_drain();

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        send(16'h3c00, 16'h3c00, 16'h0000, 16'h3c05, 1'b0, 1'b0, 4'b0000);
        send(16'h3c00, 16'h3c00, 16'h0000, 16'h3c06, 1'b0, 1'b0, 4'b0000);
        chk("full_in_ready", in_ready, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_sticky", sticky_flags, 4'b0000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(16'h3c00, 16'h4000, 16'h0000, 16'h4000, 1'b0, 1'b0, 4'b0000);
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_result", out_result, 16'h4000);
        wait_drain();
        chk("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
